// File: rtl/tv80_arith16_seq_pkg.sv
// Shared core constants for the 16-bit arithmetic sequencer: ALU operation
// codes, request operation encodings and the per-pass op selection helpers.
package tv80_arith16_seq_pkg;

    localparam logic [3:0] ALU_OP_ADD = 4'b0000;
    localparam logic [3:0] ALU_OP_ADC = 4'b0001;
    localparam logic [3:0] ALU_OP_SUB = 4'b0010;
    localparam logic [3:0] ALU_OP_SBC = 4'b0011;

    typedef enum logic [1:0] {
        OP_ADD16 = 2'b00,
        OP_ADC16 = 2'b01,
        OP_SBC16 = 2'b10,
        OP_SUB16 = 2'b11
    } arith16_op_t;

    // Low-byte pass: ADD16 and SUB16 start without carry, ADC16/SBC16 use it.
    function automatic logic [3:0] lo_pass_op(input arith16_op_t op);
        logic [3:0] code;
        case (op)
            OP_ADD16: code = ALU_OP_ADD;
            OP_ADC16: code = ALU_OP_ADC;
            OP_SBC16: code = ALU_OP_SBC;
            default:  code = ALU_OP_SUB;
        endcase
        return code;
    endfunction

    // High-byte pass always chains the carry/borrow from the low byte.
    function automatic logic [3:0] hi_pass_op(input arith16_op_t op);
        logic [3:0] code;
        case (op)
            OP_ADD16, OP_ADC16: code = ALU_OP_ADC;
            default:            code = ALU_OP_SBC;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/tv80_arith16_seq.sv
// 16-bit ADD/ADC/SUB/SBC sequencer driving an external 8-bit ALU twice
// (low byte, then high byte) with carry and flags chained between passes.
module tv80_arith16_seq
    import tv80_arith16_seq_pkg::*;
#(
    parameter int Mode   = 3,
    parameter int Flag_C = 0,
    parameter int Flag_N = 1,
    parameter int Flag_P = 2,
    parameter int Flag_X = 3,
    parameter int Flag_H = 4,
    parameter int Flag_Y = 5,
    parameter int Flag_Z = 6,
    parameter int Flag_S = 7
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [7:0]  req_f,

    output logic [3:0]  alu_op,
    output logic        alu_arith16,
    output logic        alu_z16,
    output logic [7:0]  alu_bus_a,
    output logic [7:0]  alu_bus_b,
    output logic [7:0]  alu_f_in,
    input  logic [7:0]  alu_q,
    input  logic [7:0]  alu_f_out,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_q,
    output logic [7:0]  rsp_f
);

    // Flag positions are owned by the external ALU; only sanity-checked here.
    if (Mode < 0 || Mode > 3) begin : g_bad_mode
        $error("tv80_arith16_seq: Mode out of range");
    end
    if (Flag_C < 0 || Flag_C > 7 || Flag_N < 0 || Flag_N > 7 ||
        Flag_P < 0 || Flag_P > 7 || Flag_X < 0 || Flag_X > 7 ||
        Flag_H < 0 || Flag_H > 7 || Flag_Y < 0 || Flag_Y > 7 ||
        Flag_Z < 0 || Flag_Z > 7 || Flag_S < 0 || Flag_S > 7) begin : g_bad_flag
        $error("tv80_arith16_seq: flag position out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LO   = 2'b01,
        S_HI   = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t      state;
    state_t      state_next;

    arith16_op_t op_r;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic [7:0]  f_r;
    logic [7:0]  q_lo;
    logic [7:0]  f_lo;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: one cycle per pass, DONE holds until the response is taken.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (req_valid) state_next = S_LO;
            S_LO:   state_next = S_HI;
            S_HI:   state_next = S_DONE;
            S_DONE: if (rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Request capture and per-pass result/flag capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r  <= OP_ADD16;
            a_r   <= '0;
            b_r   <= '0;
            f_r   <= '0;
            q_lo  <= '0;
            f_lo  <= '0;
            rsp_q <= '0;
            rsp_f <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_r <= arith16_op_t'(req_op);
                        a_r  <= req_a;
                        b_r  <= req_b;
                        f_r  <= req_f;
                    end
                end
                S_LO: begin
                    q_lo <= alu_q;
                    f_lo <= alu_f_out;
                end
                S_HI: begin
                    rsp_q <= {alu_q, q_lo};
                    rsp_f <= alu_f_out;
                end
                default: ;
            endcase
        end
    end

    // Outputs: handshakes from state; ALU port is quiet outside LO/HI.
    always_comb begin
        req_ready   = (state == S_IDLE);
        rsp_valid   = (state == S_DONE);
        alu_op      = '0;
        alu_arith16 = 1'b0;
        alu_z16     = 1'b0;
        alu_bus_a   = '0;
        alu_bus_b   = '0;
        alu_f_in    = '0;
        case (state)
            S_LO: begin
                alu_op      = lo_pass_op(op_r);
                alu_arith16 = (op_r == OP_ADD16);
                alu_bus_a   = a_r[7:0];
                alu_bus_b   = b_r[7:0];
                alu_f_in    = f_r;
            end
            S_HI: begin
                alu_op      = hi_pass_op(op_r);
                alu_arith16 = (op_r == OP_ADD16);
                alu_z16     = (op_r != OP_ADD16);
                alu_bus_a   = a_r[15:8];
                alu_bus_b   = b_r[15:8];
                alu_f_in    = f_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tv80_arith16_seq.sv
// Scoreboard bench for tv80_arith16_seq with a behavioural 8-bit ALU stub.
module tb_tv80_arith16_seq;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [7:0]  req_f;
    logic [3:0]  alu_op;
    logic        alu_arith16;
    logic        alu_z16;
    logic [7:0]  alu_bus_a;
    logic [7:0]  alu_bus_b;
    logic [7:0]  alu_f_in;
    logic [7:0]  alu_q;
    logic [7:0]  alu_f_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_q;
    logic [7:0]  rsp_f;

    tv80_arith16_seq #(.Mode(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_f(req_f),
        .alu_op(alu_op), .alu_arith16(alu_arith16), .alu_z16(alu_z16),
        .alu_bus_a(alu_bus_a), .alu_bus_b(alu_bus_b), .alu_f_in(alu_f_in),
        .alu_q(alu_q), .alu_f_out(alu_f_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_q(rsp_q), .rsp_f(rsp_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Z80-style 8-bit ALU: op[0] uses carry-in, op[1] subtracts.
    logic [8:0] s9;
    logic [4:0] s5;
    logic       cin;
    logic       sub;
    logic       ovf;
    always_comb begin
        sub = alu_op[1];
        cin = alu_op[0] & alu_f_in[0];
        if (sub) begin
            s9  = {1'b0, alu_bus_a} - {1'b0, alu_bus_b} - {8'b0, cin};
            s5  = {1'b0, alu_bus_a[3:0]} - {1'b0, alu_bus_b[3:0]} - {4'b0, cin};
            ovf = (alu_bus_a[7] != alu_bus_b[7]) && (s9[7] != alu_bus_a[7]);
        end else begin
            s9  = {1'b0, alu_bus_a} + {1'b0, alu_bus_b} + {8'b0, cin};
            s5  = {1'b0, alu_bus_a[3:0]} + {1'b0, alu_bus_b[3:0]} + {4'b0, cin};
            ovf = (alu_bus_a[7] == alu_bus_b[7]) && (s9[7] != alu_bus_a[7]);
        end
        alu_q        = s9[7:0];
        alu_f_out[0] = s9[8];
        alu_f_out[1] = sub;
        alu_f_out[2] = ovf;
        alu_f_out[3] = s9[3];
        alu_f_out[4] = s5[4];
        alu_f_out[5] = s9[5];
        alu_f_out[6] = (s9[7:0] == 8'h00) && (!alu_z16 || alu_f_in[6]);
        alu_f_out[7] = s9[7];
        if (alu_arith16) begin
            alu_f_out[7] = alu_f_in[7];
            alu_f_out[6] = alu_f_in[6];
            alu_f_out[2] = alu_f_in[2];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] q;
        logic [7:0]  f;
        int unsigned cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  f;
        logic [15:0] q;
        logic [7:0]  fx;
    } vec_t;

    vec_t vecs[8] = '{
        '{2'b00, 16'h0FFF, 16'h0001, 8'hC4, 16'h1000, 8'hD4},
        '{2'b10, 16'h0000, 16'h0001, 8'h01, 16'hFFFE, 8'hBB},
        '{2'b01, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 8'h51},
        '{2'b01, 16'h0100, 16'h0000, 8'h00, 16'h0100, 8'h00},
        '{2'b11, 16'h1234, 16'h0234, 8'h01, 16'h1000, 8'h02},
        '{2'b11, 16'h1234, 16'h1234, 8'h00, 16'h0000, 8'h42},
        '{2'b00, 16'h8000, 16'h8000, 8'h00, 16'h0000, 8'h01},
        '{2'b10, 16'h8000, 16'h0001, 8'h00, 16'h7FFF, 8'h3E}
    };

    // Monitor: pops on each response handshake; latency is the edge at which
    // rsp_valid is first sampled high, relative to the accepting edge.
    logic        seen = 1'b0;
    int unsigned first_cyc = 0;
    always @(negedge clk) begin
        if (reset) begin
            seen = 1'b0;
        end else begin
            if (rsp_valid && !seen) begin
                seen = 1'b1;
                first_cyc = cyc;
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_q", 32'(rsp_q), 32'(e.q));
                    chk("rsp_f", 32'(rsp_f), 32'(e.f));
                    chk("rsp_latency", first_cyc + 1 - e.cyc, 32'd3);
                end
                seen = 1'b0;
            end
        end
    end

    task automatic wait_ready();
        int unsigned n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic send(input vec_t v, input logic do_push);
        wait_ready();
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        req_f     = v.f;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        if (do_push) sb.push_back('{q: v.q, f: v.fx, cyc: cyc});
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw;
        int unsigned n;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_f     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_q", 32'(rsp_q), 32'd0);
        chk("reset_rsp_f", 32'(rsp_f), 32'd0);
        chk("reset_alu_port", 32'({alu_op, alu_arith16, alu_z16, alu_bus_a, alu_bus_b, alu_f_in}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors, consumer always ready.
        foreach (vecs[i]) send(vecs[i], 1'b1);

        // Backpressure: SBC result held while a second request waits.
        wait_ready();
        rsp_ready = 1'b0;
        send(vecs[1], 1'b1);
        req_op    = vecs[4].op;
        req_a     = vecs[4].a;
        req_b     = vecs[4].b;
        req_f     = vecs[4].f;
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_valid_seen", 32'(rsp_valid), 32'd1);
        for (int unsigned k = 0; k < 5; k++) begin
            if (k != 0) @(negedge clk);
            chk("bp_rsp_q_stable", 32'(rsp_q), 32'hFFFE);
            chk("bp_rsp_f_stable", 32'(rsp_f), 32'hBB);
            chk("bp_req_ready_low", 32'(req_ready), 32'd0);
            chk("bp_alu_op_quiet", 32'(alu_op), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_back_to_idle", 32'(req_ready), 32'd1);
        chk("bp_rsp_valid_drop", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        sb.push_back('{q: vecs[4].q, f: vecs[4].fx, cyc: cyc});
        chk("bp_next_accepted", 32'(req_ready), 32'd0);
        req_valid = 1'b0;

        // Reset during the high-byte pass abandons the operation.
        wait_ready();
        req_op    = vecs[7].op;
        req_a     = vecs[7].a;
        req_b     = vecs[7].b;
        req_f     = vecs[7].f;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("lo_alu_op", 32'(alu_op), 32'h3);
        chk("lo_alu_bus", 32'({alu_bus_a, alu_bus_b, alu_f_in}), 32'h000100);
        chk("lo_alu_z16", 32'({alu_arith16, alu_z16}), 32'd0);
        @(posedge clk);
        #1;
        chk("hi_alu_op", 32'(alu_op), 32'h3);
        chk("hi_alu_bus", 32'({alu_bus_a, alu_bus_b, alu_f_in}), 32'h8000BB);
        chk("hi_alu_z16", 32'({alu_arith16, alu_z16}), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_q", 32'(rsp_q), 32'd0);
        chk("rst_rsp_f", 32'(rsp_f), 32'd0);
        chk("rst_alu_port", 32'({alu_op, alu_arith16, alu_z16, alu_bus_a, alu_bus_b, alu_f_in}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw = saw | rsp_valid;
        end
        chk("rst_no_response", 32'(saw), 32'd0);
        send(vecs[0], 1'b1);
        send(vecs[2], 1'b1);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
